nonce_scheduler: RTL

Sequences one SHA-256d hash core through a nonce range for the miner. It takes a start command, a nonce range and a 256-bit target from the processor's memory-mapped registers, then issues nonces to the core one at a time. It compares each returned hash against the target and stops on a hit, on range exhaustion, on abort, or on a core timeout. It sits between the processor and the hash core inside Wrapper; its status bits also feed the LED and seven-segment display logic.

---
 rtl/nonce_scheduler.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/nonce_scheduler.sv
// Nonce sequencer for one SHA-256d core: issues each nonce of an inclusive range,
// checks every returned hash against the target and stops on hit, exhaustion, abort or timeout.
//
// state   | meaning
// IDLE    | no run active, waiting for cmd_start
// ISSUE   | one-cycle core_start with the current nonce
// WAIT    | waiting for core_done, timeout timer running
// CHECK   | compare the registered hash, then advance or finish
// DONE    | run finished, sticky flags held until the next start
module nonce_scheduler #(
    parameter int unsigned TIMEOUT = 200,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_start,
    input  logic             cmd_abort,
    input  logic [31:0]      nonce_first,
    input  logic [31:0]      nonce_last,
    input  logic [255:0]     target,
    output logic             core_start,
    output logic [31:0]      core_nonce,
    input  logic             core_done,
    input  logic [255:0]     core_hash,
    output logic             busy,
    output logic             found,
    output logic             exhausted,
    output logic             error,
    output logic [31:0]      found_nonce,
    output logic [CNT_W-1:0] hash_count
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        cur_nonce_q, cur_nonce_d;
    logic [31:0]        last_q, last_d;
    logic [255:0]       target_q, target_d;
    logic [255:0]       hash_q, hash_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               found_q, found_d;
    logic               exhausted_q, exhausted_d;
    logic               error_q, error_d;
    logic [31:0]        found_nonce_q, found_nonce_d;
    logic [CNT_W-1:0]   hash_count_q, hash_count_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cur_nonce_q   <= '0;
            last_q        <= '0;
            target_q      <= '0;
            hash_q        <= '0;
            timer_q       <= '0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            error_q       <= 1'b0;
            found_nonce_q <= '0;
            hash_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            cur_nonce_q   <= cur_nonce_d;
            last_q        <= last_d;
            target_q      <= target_d;
            hash_q        <= hash_d;
            timer_q       <= timer_d;
            found_q       <= found_d;
            exhausted_q   <= exhausted_d;
            error_q       <= error_d;
            found_nonce_q <= found_nonce_d;
            hash_count_q  <= hash_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cur_nonce_d   = cur_nonce_q;
        last_d        = last_q;
        target_d      = target_q;
        hash_d        = hash_q;
        timer_d       = timer_q;
        found_d       = found_q;
        exhausted_d   = exhausted_q;
        error_d       = error_q;
        found_nonce_d = found_nonce_q;
        hash_count_d  = hash_count_q;
        core_start    = 1'b0;

        // Abort overrides everything, including a same-cycle start; flags are kept.
        if (cmd_abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (cmd_start) begin
                        cur_nonce_d  = nonce_first;
                        last_d       = nonce_last;
                        target_d     = target;
                        found_d      = 1'b0;
                        exhausted_d  = 1'b0;
                        error_d      = 1'b0;
                        hash_count_d = '0;
                        state_d      = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    core_start = 1'b1;
                    timer_d    = '0;
                    state_d    = S_WAIT;
                end
                S_WAIT: begin
                    // A done landing on the timeout cycle still counts as a result.
                    if (core_done) begin
                        hash_d       = core_hash;
                        hash_count_d = hash_count_q + CNT_W'(1);
                        state_d      = S_CHECK;
                    end else if (timer_q == TMR_LAST) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                S_CHECK: begin
                    if (hash_q < target_q) begin
                        found_d       = 1'b1;
                        found_nonce_d = cur_nonce_q;
                        state_d       = S_DONE;
                    end else if (cur_nonce_q == last_q) begin
                        // Equality only: a range may legally wrap through zero.
                        exhausted_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        cur_nonce_d = cur_nonce_q + 32'd1;
                        state_d     = S_ISSUE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign busy        = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_CHECK);
    assign core_nonce  = cur_nonce_q;
    assign found       = found_q;
    assign exhausted   = exhausted_q;
    assign error       = error_q;
    assign found_nonce = found_nonce_q;
    assign hash_count  = hash_count_q;

endmodule
